spi_rom_arbiter: RTL and testbench

Shares a single SPI flash ROM, using READ command 03h, between two requesters: port 0 (display line prefetch, high priority) and port 1 (auxiliary/debug reader). It arbitrates the requests, sequences the frame (CS, CMD[7:0], ADDR[23:0], N data bytes) at SCLK = clk/2 in SPI mode 0, and returns received bytes on a shared byte stream tagged with the port id. It sits between the VGA-side fetch logic and the top-level SPI pins.

---
 rtl/spi_rom_pkg.sv | 17 +
 rtl/spi_rom_shifter.sv | 57 +++++
 rtl/spi_rom_arbiter.sv | 136 +++++++++++++
 tb/tb_spi_rom_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rom_pkg.sv
// Shared constants and FSM state type for the SPI flash ROM arbiter.
package spi_rom_pkg;

    localparam logic [7:0]  SPI_CMD_READ = 8'h03;
    localparam int unsigned SPI_CMD_LEN  = 8;
    localparam int unsigned SPI_ADDR_LEN = 24;
    localparam int unsigned SPI_HDR_LEN  = SPI_CMD_LEN + SPI_ADDR_LEN;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        GAP
    } state_e;

endpackage

// File: rtl/spi_rom_shifter.sv
// SPI mode-0 bit engine: two clk cycles per bit, 32-bit header out on MOSI, bytes in on MISO.
module spi_rom_shifter
    import spi_rom_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        run,
    input  logic [31:0] tx_word,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic [5:0]  hdr_bits,
    output logic        bit_end,
    output logic        byte_tick,
    output logic [7:0]  rx_byte
);

    logic [31:0] tx_q;
    logic [7:0]  rx_q;
    logic [2:0]  rx_cnt;
    logic        in_data;

    // sclk high marks phase B; the edge that ends it samples MISO and shifts MOSI.
    assign mosi      = tx_q[31];
    assign in_data   = (hdr_bits == 6'(SPI_HDR_LEN));
    assign bit_end   = run && sclk;
    assign byte_tick = bit_end && in_data && (rx_cnt == 3'd7);
    assign rx_byte   = {rx_q[6:0], miso};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk     <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            rx_cnt   <= '0;
            hdr_bits <= '0;
        end else if (start) begin
            sclk     <= 1'b0;
            tx_q     <= tx_word;
            rx_cnt   <= '0;
            hdr_bits <= '0;
        end else if (run) begin
            sclk <= ~sclk;
            if (sclk) begin
                tx_q <= {tx_q[30:0], 1'b0};
                if (!in_data) begin
                    hdr_bits <= hdr_bits + 6'd1;
                end else begin
                    rx_q   <= rx_byte;
                    rx_cnt <= rx_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_rom_arbiter.sv
// Fixed-priority two-port arbiter sharing one SPI flash ROM via READ frames.
module spi_rom_arbiter
    import spi_rom_pkg::*;
#(
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned CS_GAP   = 2,
    parameter logic [7:0]  READ_CMD = SPI_CMD_READ
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [23:0]      addr0,
    input  logic [LEN_W-1:0] len0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [23:0]      addr1,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt1,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             rd_id,
    output logic             done,
    output logic             busy,
    output logic             spi_cs,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_e           state;
    logic [LEN_W:0]   bytes_left;
    logic [GAP_W-1:0] gap_cnt;
    logic             owner;

    logic             start;
    logic             run;
    logic             sel_id;
    logic [23:0]      sel_addr;
    logic [LEN_W-1:0] sel_len;
    logic [5:0]       hdr_bits;
    logic             bit_end;
    logic             byte_tick;
    logic [7:0]       rx_byte;

    always_comb begin
        start    = (state == IDLE) && (req0 || req1);
        run      = (state == CMD) || (state == ADDR) || (state == DATA);
        sel_id   = !req0;
        sel_addr = req0 ? addr0 : addr1;
        sel_len  = req0 ? len0 : len1;
    end

    spi_rom_shifter u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .run       (run),
        .tx_word   ({READ_CMD, sel_addr}),
        .miso      (spi_miso),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .hdr_bits  (hdr_bits),
        .bit_end   (bit_end),
        .byte_tick (byte_tick),
        .rx_byte   (rx_byte)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            bytes_left <= '0;
            gap_cnt    <= '0;
            owner      <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_id      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            spi_cs     <= 1'b0;
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CMD;
                        spi_cs <= 1'b1;
                        busy   <= 1'b1;
                        owner  <= sel_id;
                        gnt0   <= !sel_id;
                        gnt1   <= sel_id;
                        // len of zero encodes the full 2**LEN_W bytes
                        bytes_left <= (sel_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                                      : {1'b0, sel_len};
                    end
                end
                CMD: begin
                    if (bit_end && hdr_bits == 6'(SPI_CMD_LEN - 1)) state <= ADDR;
                end
                ADDR: begin
                    if (bit_end && hdr_bits == 6'(SPI_HDR_LEN - 1)) state <= DATA;
                end
                DATA: begin
                    if (byte_tick) begin
                        rd_valid   <= 1'b1;
                        rd_data    <= rx_byte;
                        rd_id      <= owner;
                        bytes_left <= bytes_left - (LEN_W+1)'(1);
                        if (bytes_left == (LEN_W+1)'(1)) begin
                            done    <= 1'b1;
                            spi_cs  <= 1'b0;
                            state   <= GAP;
                            gap_cnt <= GAP_W'(CS_GAP - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// Directed bench for spi_rom_arbiter with a behavioural SPI flash ROM model.
module tb_spi_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [23:0] addr0, addr1;
    logic [7:0]  len0, len1;
    logic        gnt0, gnt1;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_id, done, busy;
    logic        spi_cs, spi_sclk, spi_mosi;
    logic        spi_miso = 1'b0;

    int errors = 0;
    int checks = 0;
    int cs_cnt, nvalid, ndone, ngnt1;
    logic [7:0] first_data, last_data;
    logic       last_id, done_valid;

    // ROM model state
    int          sl_n;
    logic [31:0] sl_hdr;

    always #5 clk = ~clk;

    spi_rom_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .addr0    (addr0),
        .len0     (len0),
        .gnt0     (gnt0),
        .req1     (req1),
        .addr1    (addr1),
        .len1     (len1),
        .gnt1     (gnt1),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .done     (done),
        .busy     (busy),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    function automatic logic [7:0] rom(input logic [23:0] a);
        if (a == 24'h000120) return 8'hA5;
        return a[7:0] + {a[11:8], 4'h0};
    endfunction

    // Flash model: latches MOSI on rising sclk and presents MISO for the rest of phase B.
    always @(posedge spi_sclk or posedge spi_cs) begin
        if (!spi_sclk) begin
            sl_n   = 0;
            sl_hdr = '0;
        end else begin
            if (sl_n < 32) begin
                sl_hdr = {sl_hdr[30:0], spi_mosi};
            end else begin
                int d;
                int idx;
                logic [7:0] b;
                d        = sl_n - 32;
                b        = rom(sl_hdr[23:0] + 24'(d / 8));
                idx      = 7 - (d % 8);
                spi_miso = b[idx];
            end
            sl_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (spi_cs) cs_cnt++;
        if (rd_valid) begin
            if (nvalid == 0) first_data = rd_data;
            nvalid++;
            last_data = rd_data;
            last_id   = rd_id;
        end
        if (done) begin
            ndone++;
            done_valid = rd_valid;
        end
        if (gnt1) ngnt1++;
    endtask

    task automatic clear();
        cs_cnt = 0; nvalid = 0; ndone = 0; ngnt1 = 0;
        first_data = '0; last_data = '0; last_id = 1'b0; done_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!done && k < budget);
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        clear();
        repeat (3) cyc();
        chk("reset_outputs",
            32'({spi_cs, spi_sclk, spi_mosi, gnt0, gnt1, rd_valid, done, busy, rd_id, rd_data}),
            32'd0);
        reset_n = 1'b1;
        cyc();

        // Single byte frame from port 0
        clear();
        req0 = 1'b1; addr0 = 24'h000120; len0 = 8'd1;
        cyc();
        chk("t1_gnt0", 32'(gnt0), 32'd1);
        chk("t1_cs_busy_mosi", 32'({spi_cs, busy, spi_mosi, spi_sclk, gnt1}), 32'b11000);
        req0 = 1'b0;
        cyc();
        chk("t1_gnt0_pulse", 32'({gnt0, spi_sclk}), 32'b01);
        wait_done("t1", 200);
        chk("t1_cs_len", 32'(cs_cnt), 32'd80);
        chk("t1_hdr", sl_hdr, 32'h03000120);
        chk("t1_data", 32'({last_id, last_data}), 32'h0A5);
        chk("t1_nvalid", 32'(nvalid), 32'd1);
        chk("t1_done_valid", 32'(done_valid), 32'd1);
        chk("t1_cs_low", 32'(spi_cs), 32'd0);
        repeat (5) cyc();
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Simultaneous requests, port 0 wins
        clear();
        req0 = 1'b1; addr0 = 24'h000200; len0 = 8'd2;
        req1 = 1'b1; addr1 = 24'h000300; len1 = 8'd2;
        cyc();
        chk("t2_prio", 32'({gnt0, gnt1}), 32'b10);
        wait_done("t2a", 300);
        req0 = 1'b0;
        chk("t2a_bytes", 32'({nvalid[7:0], first_data, last_data}), 32'h022021);
        chk("t2a_id", 32'(last_id), 32'd0);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!gnt1 && k < 20);
        chk("t2_gnt1_delay", 32'(k), 32'd3);
        clear();
        req1 = 1'b0;
        wait_done("t2b", 300);
        chk("t2b_bytes", 32'({nvalid[7:0], first_data, last_data}), 32'h023031);
        chk("t2b_id", 32'(last_id), 32'd1);
        repeat (5) cyc();

        // len=0 means 256 bytes
        clear();
        req0 = 1'b1; addr0 = 24'h000400; len0 = 8'd0;
        cyc();
        req0 = 1'b0;
        wait_done("t3", 5000);
        chk("t3_cs_len", 32'(cs_cnt), 32'd4160);
        chk("t3_nvalid", 32'(nvalid), 32'd256);
        chk("t3_bytes", 32'({first_data, last_data}), 32'h403F);
        repeat (3) cyc();
        chk("t3_ndone", 32'(ndone), 32'd1);

        // Reset in the ADDR phase aborts the frame
        clear();
        req0 = 1'b1; addr0 = 24'h000120; len0 = 8'd1;
        cyc();
        req0 = 1'b0;
        repeat (30) cyc();
        chk("t4_mid_frame", 32'({spi_cs, busy}), 32'b11);
        reset_n = 1'b0;
        cyc();
        chk("t4_abort_outputs",
            32'({spi_cs, spi_sclk, spi_mosi, gnt0, gnt1, rd_valid, done, busy, rd_id, rd_data}),
            32'd0);
        reset_n = 1'b1;
        repeat (10) cyc();
        chk("t4_no_done", 32'({ndone[7:0], nvalid[7:0]}), 32'd0);
        clear();
        req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        wait_done("t4_after", 200);
        chk("t4_after", 32'({cs_cnt[7:0], last_data}), 32'h50A5);
        repeat (5) cyc();

        // req1 withdrawn before grant is cancelled
        clear();
        req0 = 1'b1; addr0 = 24'h000201; len0 = 8'd1;
        cyc();
        req0 = 1'b0;
        repeat (10) cyc();
        req1 = 1'b1; addr1 = 24'h000300; len1 = 8'd1;
        repeat (10) cyc();
        req1 = 1'b0;
        wait_done("t5", 200);
        repeat (20) cyc();
        chk("t5_no_gnt1", 32'(ngnt1), 32'd0);
        chk("t5_one_frame", 32'(cs_cnt), 32'd80);
        chk("t5_quiet", 32'({spi_cs, busy, last_data}), 32'h021);

        // Held request gives back-to-back frames
        clear();
        req0 = 1'b1; addr0 = 24'h000120; len0 = 8'd1;
        cyc();
        chk("t6_gnt0_first", 32'(gnt0), 32'd1);
        addr0 = 24'h000121;
        wait_done("t6a", 200);
        chk("t6a_data", 32'(last_data), 32'hA5);
        chk("t6a_hdr", sl_hdr, 32'h03000120);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!spi_cs && k < 20);
        chk("t6_cs_low_gap", 32'(k), 32'd3);
        chk("t6_gnt0_second", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        wait_done("t6b", 200);
        chk("t6b_data", 32'(last_data), 32'h31);
        chk("t6b_hdr", sl_hdr, 32'h03000121);
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
